mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter onto a single fixed-latency line memory.
// Define MEMARB_RR_EN for round-robin tie breaking; otherwise the I-cache always wins ties.
module mem_arbiter #(
   parameter int MEM_LATENCY = 5,
   parameter int ADDR_W      = 32,
   parameter int LINE_W      = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req_ren,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_full,
   output logic              ic_rec_en,
   output logic [ADDR_W-1:0] ic_rec_addr,
   output logic [LINE_W-1:0] ic_rec_cacheline,
   input  logic              dc_req_ren,
   input  logic              dc_req_wen,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [LINE_W-1:0] dc_req_wdata,
   output logic              dc_full,
   output logic              dc_rec_en,
   output logic [ADDR_W-1:0] dc_rec_addr,
   output logic [LINE_W-1:0] dc_rec_cacheline,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   state_t            state, state_next;
   logic              gnt_dc, gnt_dc_next;
   logic [3:0]        cnt;

   logic              ic_valid;
   logic [ADDR_W-1:0] ic_addr_q;
   logic              dc_valid;
   logic              dc_we_q;
   logic [ADDR_W-1:0] dc_addr_q;
   logic [LINE_W-1:0] dc_wdata_q;

   logic              ic_take, dc_take, ic_pend, dc_pend, pick_dc, done, granted_we;

   assign ic_take    = ic_req_ren & ~ic_valid;
   assign dc_take    = (dc_req_ren | dc_req_wen) & ~dc_valid;
   // A pulse arriving while IDLE is arbitrated in the same cycle it is captured.
   assign ic_pend    = ic_valid | ic_take;
   assign dc_pend    = dc_valid | dc_take;
   assign done       = (state == WAIT) && (cnt == 4'd0);
   assign granted_we = gnt_dc & dc_we_q;

`ifdef MEMARB_RR_EN
   logic last_dc;

   assign pick_dc = dc_pend & (~ic_pend | ~last_dc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_dc <= 1'b1;
      else if (state == IDLE && (ic_pend || dc_pend))
         last_dc <= pick_dc;
   end
`else
   assign pick_dc = dc_pend & ~ic_pend;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         gnt_dc <= 1'b0;
      end else begin
         state  <= state_next;
         gnt_dc <= gnt_dc_next;
      end
   end

   always_comb begin
      state_next  = state;
      gnt_dc_next = gnt_dc;
      mem_en      = 1'b0;
      case (state)
         IDLE: begin
            if (ic_pend || dc_pend) begin
               gnt_dc_next = pick_dc;
               state_next  = ISSUE;
            end
         end
         ISSUE: begin
            mem_en     = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (cnt == 4'd0)
               state_next = granted_we ? IDLE : RESP;
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign mem_we    = mem_en & granted_we;
   assign mem_addr  = mem_en ? (gnt_dc ? dc_addr_q : ic_addr_q) : '0;
   assign mem_wdata = mem_we ? dc_wdata_q : '0;
   assign ic_rec_en = (state == RESP) && !gnt_dc;
   assign dc_rec_en = (state == RESP) && gnt_dc;
   assign ic_full   = ic_valid;
   assign dc_full   = dc_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= 4'd0;
      else if (state == ISSUE)
         cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != 4'd0)
         cnt <= cnt - 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ic_valid  <= 1'b0;
         ic_addr_q <= '0;
      end else if (done && !gnt_dc) begin
         ic_valid  <= 1'b0;
      end else if (ic_take) begin
         ic_valid  <= 1'b1;
         ic_addr_q <= ic_req_addr;
      end
   end

   // A simultaneous read and write pulse is recorded as a write-back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dc_valid   <= 1'b0;
         dc_we_q    <= 1'b0;
         dc_addr_q  <= '0;
         dc_wdata_q <= '0;
      end else if (done && gnt_dc) begin
         dc_valid   <= 1'b0;
      end else if (dc_take) begin
         dc_valid   <= 1'b1;
         dc_we_q    <= dc_req_wen;
         dc_addr_q  <= dc_req_addr;
         dc_wdata_q <= dc_req_wdata;
      end
   end

   // Per-requester fill registers so each side keeps its last line between fills.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ic_rec_addr      <= '0;
         ic_rec_cacheline <= '0;
         dc_rec_addr      <= '0;
         dc_rec_cacheline <= '0;
      end else if (done && !granted_we) begin
         if (gnt_dc) begin
            dc_rec_addr      <= dc_addr_q;
            dc_rec_cacheline <= mem_rdata;
         end else begin
            ic_rec_addr      <= ic_addr_q;
            ic_rec_cacheline <= mem_rdata;
         end
      end
   end

endmodule
